// File: rtl/mdio_master_param_if.sv
// mdio_master_param_if: request, status and serial-line bundle for mdio_master_param
// master modport: DUT side (takes request fields and MDIO_IN, drives MDC/MDIO and status)
// slave modport: requester/PHY side (mirror of master)
interface mdio_master_param_if #(parameter int DATA_W = 16);
   logic              MDIO_START;
   logic [1:0]        OP;
   logic [4:0]        PHY_ADDR;
   logic [4:0]        REG_ADDR;
   logic [DATA_W-1:0] WR_DATA;
   logic              CL45;
   logic              MDIO_IN;
   logic              MDC;
   logic              MDIO_OUT;
   logic              MDIO_OE;
   logic [DATA_W-1:0] RD_DATA;
   logic              DATA_RDY;
   logic              BUSY;
   logic              TA_ERR;
   modport master(input MDIO_START, OP, PHY_ADDR, REG_ADDR, WR_DATA, CL45, MDIO_IN,
                  output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY, TA_ERR);
   modport slave(output MDIO_START, OP, PHY_ADDR, REG_ADDR, WR_DATA, CL45, MDIO_IN,
                 input MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY, TA_ERR);
endinterface

// File: rtl/mdio_master_param.sv
// mdio_master_param: Clause 22 MDIO management master with MDC divider; MDIO_CLAUSE45_EN adds Clause 45 framing
// Ports: clk; reset (sync, active-high); bus (mdio_master_param_if.master):
//   MDIO_START/OP/PHY_ADDR/REG_ADDR/WR_DATA/CL45 request, MDIO_IN from PHY,
//   MDC/MDIO_OUT/MDIO_OE serial line, RD_DATA/DATA_RDY/BUSY/TA_ERR status.
module mdio_master_param #(
   parameter int CLK_DIV      = 2,
   parameter int PREAMBLE_LEN = 32,
   parameter int DATA_W       = 16
) (
   input logic                 clk,
   input logic                 reset,
   mdio_master_param_if.master bus
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int FW = 16 + DATA_W;
   typedef enum logic [2:0] {IDLE, PRE, ST, OPC, PHY, REG, TA, DATA} state_t;
   state_t            state_q, state_d, nxt;
   logic [DW-1:0]     div_q, div_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [FW-1:0]     tx_q, tx_d, frame;
   logic [DATA_W-1:0] sh_q, sh_d, rd_q, rd_d;
   logic              rd_op_q, rd_op_d, mdc_q, mdc_d, out_q, out_d, oe_q, oe_d;
   logic              rdy_q, rdy_d, busy_q, busy_d, err_q, err_d;
   logic [1:0]        st;
   logic              wrap, rise, fall, last, bit_v, oe_v;
`ifdef MDIO_CLAUSE45_EN
   assign st = bus.CL45 ? 2'b00 : 2'b01;
`else
   logic unused_cl45;
   assign unused_cl45 = bus.CL45;
   assign st = 2'b01;
`endif
   // Everything after the preamble goes out of one shift register; TA is preloaded as 10.
   assign frame = {st, bus.OP, bus.PHY_ADDR, bus.REG_ADDR, 2'b10, bus.WR_DATA};
   // Bits remaining in a field, minus one.
   function automatic logic [5:0] len_m1(state_t s);
      return s == PRE ? 6'(PREAMBLE_LEN - 1) : s == DATA ? 6'(DATA_W - 1) :
             (s == PHY || s == REG) ? 6'd4 : 6'd1;
   endfunction
   always_comb begin
      wrap    = div_q == DW'(CLK_DIV - 1);
      rise    = busy_q && wrap && !mdc_q;
      fall    = busy_q && wrap && mdc_q;
      last    = cnt_q == 6'd0;
      nxt     = state_q == PRE ? ST : state_q == ST ? OPC : state_q == OPC ? PHY :
                state_q == PHY ? REG : state_q == REG ? TA : state_q == TA ? DATA : IDLE;
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      sh_d    = sh_q;
      rd_d    = rd_q;
      rd_op_d = rd_op_q;
      mdc_d   = mdc_q;
      out_d   = out_q;
      oe_d    = oe_q;
      rdy_d   = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      bit_v   = 1'b0;
      oe_v    = 1'b0;
      if (state_q == IDLE) begin
         if (bus.MDIO_START) begin
            state_d = PREAMBLE_LEN > 0 ? PRE : ST;
            cnt_d   = len_m1(state_d);
            tx_d    = frame;
            rd_op_d = bus.OP[1];
            err_d   = 1'b0;
            busy_d  = 1'b1;
            div_d   = '0;
            mdc_d   = 1'b0;
            out_d   = PREAMBLE_LEN > 0 ? 1'b1 : frame[FW-1];
            oe_d    = 1'b1;
         end
      end else begin
         div_d = wrap ? '0 : div_q + DW'(1);
         mdc_d = wrap ? !mdc_q : mdc_q;
         if (rise && rd_op_q && state_q == TA && last && bus.MDIO_IN) err_d = 1'b1;
         if (rise && rd_op_q && state_q == DATA) sh_d = {sh_q[DATA_W-2:0], bus.MDIO_IN};
         if (fall) begin
            state_d = last ? nxt : state_q;
            cnt_d   = last ? len_m1(nxt) : cnt_q - 6'd1;
            // The shift register only advances for bits it actually supplied.
            tx_d    = state_q == PRE ? tx_q : tx_q << 1;
            bit_v   = state_d == PRE ? 1'b1 : tx_d[FW-1];
            oe_v    = (!rd_op_q || !(state_d == TA || state_d == DATA)) && state_d != IDLE;
            out_d   = oe_v && bit_v;
            oe_d    = oe_v;
            if (state_d == IDLE) begin
               busy_d = 1'b0;
               mdc_d  = 1'b0;
               div_d  = '0;
               rdy_d  = 1'b1;
               rd_d   = rd_op_q ? sh_q : rd_q;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= '0;
         sh_q    <= '0;
         rd_q    <= '0;
         rd_op_q <= 1'b0;
         mdc_q   <= 1'b0;
         out_q   <= 1'b0;
         oe_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         sh_q    <= sh_d;
         rd_q    <= rd_d;
         rd_op_q <= rd_op_d;
         mdc_q   <= mdc_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end
   assign bus.MDC      = mdc_q;
   assign bus.MDIO_OUT = out_q;
   assign bus.MDIO_OE  = oe_q;
   assign bus.RD_DATA  = rd_q;
   assign bus.DATA_RDY = rdy_q;
   assign bus.BUSY     = busy_q;
   assign bus.TA_ERR   = err_q;
endmodule

// File: tb/tb_mdio_master_param.sv
// tb_mdio_master_param: scoreboard bench for mdio_master_param (default build and MDIO_CLAUSE45_EN)
module tb_mdio_master_param;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   logic        sel = 1'b0, start = 1'b0, cl45 = 1'b0, mdio_in = 1'b1;
   logic [1:0]  op = 2'b00;
   logic [4:0]  phy = 5'd0, regad = 5'd0;
   logic [15:0] wr = 16'd0;
   mdio_master_param_if #(.DATA_W(16)) b1 ();
   mdio_master_param_if #(.DATA_W(16)) b2 ();
   mdio_master_param #(.CLK_DIV(2), .PREAMBLE_LEN(32), .DATA_W(16)) dut (.clk(clk), .reset(reset), .bus(b1));
   mdio_master_param #(.CLK_DIV(3), .PREAMBLE_LEN(0), .DATA_W(16)) dut2 (.clk(clk), .reset(reset), .bus(b2));
   assign b1.MDIO_START = start & ~sel;
   assign b2.MDIO_START = start & sel;
   assign b1.OP = op;         assign b2.OP = op;
   assign b1.PHY_ADDR = phy;  assign b2.PHY_ADDR = phy;
   assign b1.REG_ADDR = regad; assign b2.REG_ADDR = regad;
   assign b1.WR_DATA = wr;    assign b2.WR_DATA = wr;
   assign b1.CL45 = cl45;     assign b2.CL45 = cl45;
   assign b1.MDIO_IN = mdio_in; assign b2.MDIO_IN = mdio_in;
   logic        mdc_o, out_o, oe_o, rdy_o, busy_o, err_o;
   logic [15:0] rd_o;
   assign mdc_o  = sel ? b2.MDC : b1.MDC;
   assign out_o  = sel ? b2.MDIO_OUT : b1.MDIO_OUT;
   assign oe_o   = sel ? b2.MDIO_OE : b1.MDIO_OE;
   assign rdy_o  = sel ? b2.DATA_RDY : b1.DATA_RDY;
   assign busy_o = sel ? b2.BUSY : b1.BUSY;
   assign err_o  = sel ? b2.TA_ERR : b1.TA_ERR;
   assign rd_o   = sel ? b2.RD_DATA : b1.RD_DATA;
   int passed = 0, total = 0;
   logic [1:0] exp_q[$];
   function automatic logic phy_bit(int nr, int pre, logic ta, logic [15:0] d);
      if (nr == pre + 15) return ta;
      if (nr >= pre + 16 && nr < pre + 32) return d[15 - (nr - pre - 16)];
      return 1'b1;
   endfunction
   // Runs one frame on the selected DUT; expected serial bits go to the scoreboard at start.
   task automatic do_frame(input string nm, input logic [1:0] op_i, input logic [4:0] phy_i,
                           input logic [4:0] reg_i, input logic [15:0] wr_i, input logic cl45_i,
                           input logic phy_ta, input logic [15:0] phy_data, input bit mid_start);
      int pre, dv, busy_n, rdy_n, nr, idle;
      logic rd, prev, rd_hold;
      logic [1:0] st_e, e;
      logic [31:0] fr;
      logic [15:0] rd_old, got;
      pre = sel ? 0 : 32;
      dv = sel ? 3 : 2;
      rd = op_i[1];
      st_e = 2'b01;
`ifdef MDIO_CLAUSE45_EN
      if (cl45_i) st_e = 2'b00;
`endif
      fr = {st_e, op_i, phy_i, reg_i, 2'b10, wr_i};
      exp_q.delete();
      for (int i = 0; i < pre; i++) exp_q.push_back(2'b11);
      for (int i = 0; i < 32; i++) exp_q.push_back({!rd || i < 14, fr[31-i]});
      op = op_i; phy = phy_i; regad = reg_i; wr = wr_i; cl45 = cl45_i; mdio_in = 1'b1;
      rd_old = rd_o;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy_o !== 1'b1) $display("FAIL %s start_busy got %b want 1", nm, busy_o); else passed++;
      total++;
      if (err_o !== 1'b0) $display("FAIL %s ta_err_cleared got %b want 0", nm, err_o); else passed++;
      busy_n = 0; rdy_n = 0; nr = 0; idle = 0; prev = 1'b0; rd_hold = 1'b1; got = 16'hxxxx;
      for (int c = 0; c < 3000 && idle < 4; c++) begin
         if (busy_o) busy_n++; else idle++;
         if (busy_o && rd_o !== rd_old) rd_hold = 1'b0;
         if (rdy_o) begin rdy_n++; got = rd_o; end
         if (mdc_o && !prev) begin
            total++;
            if (exp_q.size() == 0) $display("FAIL %s extra_bit %0d got oe=%b out=%b want none", nm, nr, oe_o, out_o);
            else begin
               e = exp_q.pop_front();
               if (oe_o !== e[1] || (e[1] && out_o !== e[0]))
                  $display("FAIL %s bit%0d got oe=%b out=%b want oe=%b out=%b", nm, nr, oe_o, out_o, e[1], e[0]);
               else passed++;
            end
            nr++;
         end
         prev = mdc_o;
         mdio_in = phy_bit(nr, pre, phy_ta, phy_data);
         if (mid_start) begin
            start = c == 100;
            if (c == 100) begin op = ~op_i; phy = ~phy_i; regad = ~reg_i; wr = ~wr_i; end
         end
         @(negedge clk);
      end
      start = 1'b0;
      total++;
      if (exp_q.size() != 0) $display("FAIL %s bits_left got %0d want 0", nm, exp_q.size()); else passed++;
      total++;
      if (busy_n != (pre + 32) * 2 * dv) $display("FAIL %s busy_cycles got %0d want %0d", nm, busy_n, (pre + 32) * 2 * dv); else passed++;
      total++;
      if (rdy_n != 1) $display("FAIL %s data_rdy_pulses got %0d want 1", nm, rdy_n); else passed++;
      total++;
      if (err_o !== (rd & phy_ta)) $display("FAIL %s ta_err got %b want %b", nm, err_o, rd & phy_ta); else passed++;
      total++;
      if (got !== (rd ? phy_data : rd_old)) $display("FAIL %s rd_data got %h want %h", nm, got, rd ? phy_data : rd_old); else passed++;
      total++;
      if (!rd_hold) $display("FAIL %s rd_data_hold got changed want %h", nm, rd_old); else passed++;
   endtask
   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({b1.MDC, b1.MDIO_OUT, b1.MDIO_OE, b1.RD_DATA, b1.DATA_RDY, b1.BUSY, b1.TA_ERR} !== 22'd0)
         $display("FAIL reset_dut got mdc=%b out=%b oe=%b rd=%h rdy=%b busy=%b err=%b want all 0",
                  b1.MDC, b1.MDIO_OUT, b1.MDIO_OE, b1.RD_DATA, b1.DATA_RDY, b1.BUSY, b1.TA_ERR);
      else passed++;
      total++;
      if ({b2.MDC, b2.MDIO_OUT, b2.MDIO_OE, b2.RD_DATA, b2.DATA_RDY, b2.BUSY, b2.TA_ERR} !== 22'd0)
         $display("FAIL reset_dut2 got mdc=%b oe=%b rd=%h busy=%b want all 0", b2.MDC, b2.MDIO_OE, b2.RD_DATA, b2.BUSY);
      else passed++;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (b1.MDC !== 1'b0 || b1.BUSY !== 1'b0) $display("FAIL idle_mdc got mdc=%b busy=%b want 0 0", b1.MDC, b1.BUSY); else passed++;
   endtask
   task automatic test_write();
      do_frame("write", 2'b01, 5'h01, 5'h02, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0);
   endtask
   task automatic test_read();
      do_frame("read", 2'b10, 5'h03, 5'h04, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0);
   endtask
   task automatic test_ta_err();
      do_frame("ta_err", 2'b10, 5'h05, 5'h06, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 1'b0);
      do_frame("ta_clear", 2'b10, 5'h07, 5'h08, 16'h0000, 1'b0, 1'b0, 16'hC3E1, 1'b0);
   endtask
   task automatic test_start_busy();
      do_frame("start_busy", 2'b01, 5'h11, 5'h12, 16'h8001, 1'b0, 1'b0, 16'h0000, 1'b1);
   endtask
   task automatic test_reset_mid();
      int seen;
      sel = 1'b0; op = 2'b01; phy = 5'h0A; regad = 5'h0B; wr = 16'hF00F;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (220) @(negedge clk);
      total++;
      if (busy_o !== 1'b1) $display("FAIL reset_mid_busy got %b want 1", busy_o); else passed++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if ({mdc_o, out_o, oe_o, rd_o, rdy_o, busy_o, err_o} !== 22'd0)
         $display("FAIL reset_mid_outputs got mdc=%b out=%b oe=%b rd=%h rdy=%b busy=%b err=%b want all 0",
                  mdc_o, out_o, oe_o, rd_o, rdy_o, busy_o, err_o);
      else passed++;
      seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (rdy_o || busy_o) seen++;
      end
      total++;
      if (seen != 0) $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen); else passed++;
      do_frame("after_reset", 2'b01, 5'h1F, 5'h00, 16'h1357, 1'b0, 1'b0, 16'h0000, 1'b0);
   endtask
   task automatic test_preamble_c45();
      sel = 1'b1;
      @(negedge clk);
      do_frame("c45_addr", 2'b00, 5'h03, 5'h04, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0);
      do_frame("c45_read", 2'b11, 5'h02, 5'h01, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0);
      sel = 1'b0;
   endtask
   initial begin
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_ta_err();
      test_start_busy();
      test_reset_mid();
      test_preamble_c45();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mdio_master_param.md
Name: mdio_master_param

Overview:
Parametrised successor MDIO management master (IEEE 802.3 Clause 22, optional Clause 45) for the PHY management path.
- Generates MDC from the system clock with a configurable divider.
- Serialises complete management frames from structured fields and handles turnaround correctly for writes and reads.
- Deserialises read data, flags turnaround errors, and reports completion over a start/busy/done handshake.

Parameters:
CLK_DIV, 2, system clk cycles per MDC half-period (legal >= 2); MDC bit period = 2*CLK_DIV cycles
PREAMBLE_LEN, 32, number of preamble '1' bits (legal 0..32; 0 = preamble suppression)
DATA_W, 16, width of the data field and RD_DATA (fixed 16 for standard compliance; kept as a parameter for the bench)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MDIO_START  input  1  start request; accepted only when BUSY=0
OP  input  2  opcode: 01 write, 10 read (Clause 45 codes listed under Optional Feature)
PHY_ADDR  input  5  PHYAD (PRTAD in Clause 45)
REG_ADDR  input  5  REGAD (DEVAD in Clause 45)
WR_DATA  input  DATA_W  write data, or address for a Clause 45 address frame
CL45  input  1  frame type select: 1 = Clause 45 frame; ignored when the macro is off
MDIO_IN  input  1  serial data from the PHY
MDC  output  1  management clock
MDIO_OUT  output  1  serial data to the PHY
MDIO_OE  output  1  tristate enable; 1 = master drives the line
RD_DATA  output  DATA_W  last read data
DATA_RDY  output  1  one-cycle pulse at frame completion
BUSY  output  1  frame in progress
TA_ERR  output  1  read turnaround error; sticky until the next accepted start

Behaviour:
- Reset values: MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=0, DATA_RDY=0, BUSY=0, TA_ERR=0, state=IDLE.
- Reset mid-frame: all outputs return to reset values on the next edge; the frame is aborted with no DATA_RDY.
- Start acceptance:
  - MDIO_START sampled high in IDLE latches OP/PHY_ADDR/REG_ADDR/WR_DATA/CL45, clears TA_ERR, and sets BUSY=1 on the same edge.
  - MDIO_START while BUSY=1 is ignored; the latched fields are unaffected.
- MDC: held 0 in IDLE; toggles every CLK_DIV cycles while BUSY.
  - Each bit starts with MDC low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MDIO_OUT/MDIO_OE update at bit start (MDC falling edge or frame start).
  - MDIO_IN is sampled on the clk edge where MDC goes 0->1.
- States and bit counts:
  - PRE: PREAMBLE_LEN bits; skipped when PREAMBLE_LEN=0.
  - ST: 2 bits, 01 (00 for Clause 45).
  - OP: 2 bits, MSB first.
  - PHY: 5 bits, MSB first.
  - REG: 5 bits, MSB first.
  - TA: 2 bits.
  - DATA: DATA_W bits, MSB first.
  - Then IDLE.
- Write frames (OP[1]=0): MDIO_OE=1 for the whole frame; TA driven as 1,0; DATA driven from WR_DATA.
- Read frames (OP[1]=1):
  - MDIO_OE=1 through the REG field.
  - MDIO_OE=0 from the start of the first TA bit to end of frame.
  - Second TA bit sampled; a value of 1 sets TA_ERR.
  - DATA bits shifted into a shadow register. RD_DATA updates only at completion, so it keeps its old value during the frame.
- Completion, on the edge ending the last DATA bit's high phase:
  - BUSY=0, MDC=0, MDIO_OE=0, MDIO_OUT=0.
  - DATA_RDY=1 for exactly one cycle, for reads and writes.
  - A new start is accepted on the following cycle.
- Frame duration: (PREAMBLE_LEN+32)*2*CLK_DIV clk cycles of BUSY.
- Counters: bit counter 6 bits; divider counter ceil(log2(CLK_DIV)) bits, wraps at CLK_DIV-1.

Optional Feature:
MDIO_CLAUSE45_EN
- Defined: CL45=1 sends ST=00, and OP is 00 address, 01 write, 11 read, or 10 read-increment.
  - 00 and 01 are write-type (master drives TA and DATA).
  - 11 and 10 are read-type.
- Not defined: CL45 is ignored; ST is always 01 and only OP 01/10 are valid. Any other OP is sent verbatim: OP[1]=1 is treated as a read, OP[1]=0 as a write.

Test Plan:
- Write frame: CLK_DIV=2, PREAMBLE_LEN=32, OP=01, PHY=5'h01, REG=5'h02, WR_DATA=16'hABCD.
  - Serial bits: 32x'1', then 01 01 00001 00010 10 1010101111001101.
  - MDIO_OE=1 throughout; BUSY high 256 cycles; one DATA_RDY pulse.
- Read frame: OP=10, PHY model drives TA 0 then 16'h1234.
  - RD_DATA=16'h1234 at DATA_RDY; MDIO_OE=0 for the last 18 bits; TA_ERR=0.
- TA error: read with the PHY leaving the line at 1 during TA.
  - TA_ERR=1 after the frame; DATA_RDY still pulses; TA_ERR cleared by the next start.
- Start while busy: pulse MDIO_START mid-frame with different fields.
  - The frame is unchanged; no second frame; BUSY low exactly at the first frame's end.
- Reset mid-frame: assert reset during the DATA field.
  - Next cycle all outputs equal reset values; no DATA_RDY; a new start afterwards produces a correct frame.
- Preamble suppression / Clause 45 (PREAMBLE_LEN=0, CLK_DIV=3, macro on, CL45=1, OP=00, WR_DATA=16'h0100).
  - First bits are 00 00; BUSY lasts 192 cycles.
